frame_mem_host: RTL and testbench
=================================

// Module: frame_mem_host
// PURPOSE
// - Memory-side responder and sequencer for the edge-detection accelerator (acc).
// - Owns the frame memory. Serves acc's addr/en/we/dataR/dataW bus with 1-cycle read latency.
// - Host side: streams the input image in, drives acc start, waits for finish, streams the result region out.
// PARAMETERS
// - DEPTH      50688  words of frame memory (input image + result image)
// - IMG_WORDS  25344  words per image (88 words x 288 rows)
// - RES_BASE   25344  word address of first result word
// PORTS
// - clk        in   1   clock
// - reset      in   1   asynchronous reset, active-low
// - addr       in   16  acc word address
// - dataR      out  32  acc read data, registered
// - dataW      in   32  acc write data
// - en         in   1   acc access request
// - we         in   1   acc write (1) / read (0)
// - start      out  1   run request to acc
// - finish     in   1   acc completion, level
// - go         in   1   host: begin load/run/dump sequence
// - in_valid   in   1   host input word valid
// - in_ready   out  1   host input word accepted when valid&ready
// - in_data    in   32  host input word
// - out_valid  out  1   result word valid
// - out_ready  in   1   host sink ready
// - out_data   out  32  result word
// - busy       out  1   sequence in progress (state != IDLE)
// - done       out  1   1-cycle pulse, sequence complete
// BEHAVIOUR
// - Reset (reset=0, async):
//   - Outputs: dataR=0, start=0, in_ready=0, out_valid=0, out_data=0, busy=0, done=0.
//   - State=IDLE; all counters=0; memory contents not cleared.
// - FSM IDLE->LOAD->RUN->DUMP->FIN->IDLE.
//   - IDLE: go=1 -> LOAD, load counter=0. go is ignored in every other state.
//   - LOAD: in_ready=1.
//     - Each valid&ready writes in_data to mem[cnt], then cnt++.
//     - Transfer with cnt==IMG_WORDS-1 -> RUN. in_ready=0 from the next cycle.
//   - RUN:
//     - start=1 from the first RUN cycle while finish=0.
//     - finish=1 sampled -> start=0 in the same cycle (combinational), next state DUMP.
//   - DUMP:
//     - Reads mem[RES_BASE+k], k=0..IMG_WORDS-1, through a 2-entry output FIFO.
//     - A read is issued only if FIFO occupancy plus in-flight reads < 2.
//     - out_valid = FIFO not empty. A word pops on out_valid&out_ready.
//     - In-order delivery; no loss or duplication under any out_ready pattern.
//     - Last word popped -> FIN.
//   - FIN: done=1 for exactly one cycle, then -> IDLE.
// - Acc port, active only in RUN:
//   - en&we: mem[addr]<=dataW at the clock edge.
//   - en&!we: dataR<=mem[addr], valid on the following cycle.
//   - en=0: dataR holds its value.
//   - addr>=DEPTH: write dropped; read returns dataR=0.
//   - Outside RUN: acc requests are ignored and dataR holds.
// - The single RAM port is muxed by state (LOAD: host write; RUN: acc; DUMP: dump read), so there are no conflicts.
// - Writes followed by a read of the same address on the next cycle return the new data. There is no same-cycle read-during-write.
// - Counters are 16-bit unsigned. IMG_WORDS <= DEPTH - RES_BASE is checked by an elaboration assert.
// - Reset asserted in any state aborts immediately to IDLE. The output FIFO is flushed, and an in-flight read is discarded.
// STRUCTURE
// - Package acc_pkg:
//   - IMG_WORDS, RES_BASE, DEPTH constants.
//   - typedef enum logic[2:0] fm_state_t {IDLE,LOAD,RUN,DUMP,FIN}.
//   - word_t (logic[31:0]), halfword_t (logic[15:0]).
// - Sub-module frame_sram: single-port synchronous RAM (DEPTH x 32).
//   - Inputs: en, we, addr, wdata. Output: registered rdata, 1-cycle latency.
//   - No reset on the array.
// - Top: FSM, counters, port mux, 2-entry output FIFO.
// TESTING
// - Reset: hold reset=0 mid-stream -> all outputs 0, busy=0. Release -> stays IDLE until go.
// - Load/read: go, stream words value=i (i=0..25343) with in_valid always 1.
//   - -> in_ready falls after 25344 transfers; start=1 next cycle.
//   - Acc model reads addr 5 -> dataR=5 one cycle later.
// - Write/dump:
//   - Acc writes 0xDEADBEEF at 25347, then finish=1 -> start=0.
//   - Dump word 3 = 0xDEADBEEF.
//   - out_ready random 50% -> exactly 25344 words, in order; done pulses once.
// - Range: in RUN, acc writes addr 50688 -> no memory change; reads addr 50690 -> dataR=0.
// - Ignored inputs: go during RUN and in_valid during RUN/DUMP -> no state change, in_ready=0, memory unchanged.
// - Abort: reset=0 during DUMP after 100 words -> out_valid=0 immediately.
//   - New go -> full sequence completes correctly.

Source files
------------

// File: rtl/acc_pkg.sv
// acc_pkg: frame memory geometry, sequencer states and word types shared by frame_mem_host
package acc_pkg;
  typedef logic [31:0] word_t;
  typedef logic [15:0] halfword_t;
  localparam halfword_t DEPTH = 16'd50688;
  localparam halfword_t IMG_WORDS = 16'd25344;
  localparam halfword_t RES_BASE = 16'd25344;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, DUMP, FIN} fm_state_t;
endpackage

// File: rtl/frame_sram.sv
// frame_sram: single-port DEPTH x 32 sync RAM; ports clk, en, we, addr, wdata in; registered rdata out (1-cycle read latency)
module frame_sram
  import acc_pkg::*;
(
  input  logic      clk,
  input  logic      en,
  input  logic      we,
  input  halfword_t addr,
  input  word_t     wdata,
  output word_t     rdata
);
  word_t r_mem [DEPTH];
  always_ff @(posedge clk)
    if (en) begin
      if (we) r_mem[addr] <= wdata;
      else rdata <= r_mem[addr];
    end
endmodule

// File: rtl/frame_mem_host.sv
// frame_mem_host: frame memory + load/run/dump sequencer; ports: acc bus (addr/en/we/dataW/dataR), start/finish, host in/out streams, go/busy/done
module frame_mem_host
  import acc_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  halfword_t addr,
  output word_t     dataR,
  input  word_t     dataW,
  input  logic      en,
  input  logic      we,
  output logic      start,
  input  logic      finish,
  input  logic      go,
  input  logic      in_valid,
  output logic      in_ready,
  input  word_t     in_data,
  output logic      out_valid,
  input  logic      out_ready,
  output word_t     out_data,
  output logic      busy,
  output logic      done
);
  fm_state_t r_state, w_next;
  halfword_t r_cnt, r_pop;
  logic [1:0] r_occ;
  logic r_inflight, r_wp, r_rp, r_acc_pend;
  word_t r_fifo [2];
  word_t r_dr, w_rdata, w_ram_wdata;
  halfword_t w_ram_addr;
  logic w_ram_en, w_ram_we, w_issue, w_pop, w_acc_ok, w_oob_rd;

  if (IMG_WORDS > DEPTH - RES_BASE) begin : g_size_check
    $error("IMG_WORDS exceeds the result region");
  end

  frame_sram u_sram (
    .clk(clk), .en(w_ram_en), .we(w_ram_we), .addr(w_ram_addr), .wdata(w_ram_wdata), .rdata(w_rdata)
  );

  assign w_acc_ok = (r_state == RUN) && en && (addr < DEPTH);
  assign w_oob_rd = (r_state == RUN) && en && !we && (addr >= DEPTH);
  assign w_issue = (r_state == DUMP) && (r_cnt < IMG_WORDS) && ((r_occ + {1'b0, r_inflight}) < 2'd2);
  assign w_pop = out_valid && out_ready;
  assign out_valid = r_occ != 2'd0;
  assign out_data = r_fifo[r_rp];
  // the RAM output register is shared with dump reads, so acc read data is
  // taken from the RAM only in the cycle right after an acc read, else held
  assign dataR = r_acc_pend ? w_rdata : r_dr;

  always_comb begin
    w_next = r_state;
    in_ready = 1'b0;
    start = 1'b0;
    done = 1'b0;
    busy = r_state != IDLE;
    w_ram_en = 1'b0;
    w_ram_we = 1'b0;
    w_ram_addr = r_cnt;
    w_ram_wdata = in_data;
    case (r_state)
      IDLE: w_next = go ? LOAD : IDLE;
      LOAD: begin
        in_ready = 1'b1;
        w_ram_en = in_valid;
        w_ram_we = 1'b1;
        w_next = (in_valid && r_cnt == IMG_WORDS - 16'd1) ? RUN : LOAD;
      end
      RUN: begin
        start = !finish;
        w_ram_en = w_acc_ok;
        w_ram_we = we;
        w_ram_addr = addr;
        w_ram_wdata = dataW;
        w_next = finish ? DUMP : RUN;
      end
      DUMP: begin
        w_ram_en = w_issue;
        w_ram_addr = RES_BASE + r_cnt;
        w_next = (w_pop && r_pop == IMG_WORDS - 16'd1) ? FIN : DUMP;
      end
      FIN: begin
        done = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= IDLE;
    else r_state <= w_next;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_cnt <= '0;
      r_pop <= '0;
      r_occ <= '0;
      r_inflight <= 1'b0;
      r_wp <= 1'b0;
      r_rp <= 1'b0;
      r_fifo[0] <= '0;
      r_fifo[1] <= '0;
      r_acc_pend <= 1'b0;
      r_dr <= '0;
    end else begin
      r_cnt <= (r_state == IDLE || r_state == RUN) ? '0 :
               ((r_state == LOAD && in_valid) || w_issue) ? r_cnt + 16'd1 : r_cnt;
      r_pop <= (r_state == DUMP) ? r_pop + {15'b0, w_pop} : '0;
      r_acc_pend <= w_acc_ok && !we;
      r_dr <= w_oob_rd ? '0 : r_acc_pend ? w_rdata : r_dr;
      r_inflight <= w_issue;
      if (r_inflight) begin
        r_fifo[r_wp] <= w_rdata;
        r_wp <= !r_wp;
      end
      if (w_pop) r_rp <= !r_rp;
      r_occ <= r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
    end
endmodule

// File: tb/tb_frame_mem_host.sv
// tb_frame_mem_host: directed self-checking bench for frame_mem_host
module tb_frame_mem_host;
  import acc_pkg::*;
  localparam int IMG = 25344;
  localparam int RB = 25344;
  logic clk = 1'b0;
  logic reset = 1'b1;
  halfword_t addr;
  word_t dataR, dataW, in_data, out_data;
  logic en, we, start, finish, go, in_valid, in_ready, out_valid, out_ready, busy, done;
  int n_assert = 0;
  int n_fail = 0;
  int kpos [7] = '{0, 1, 2, 3, 100, 12345, 25343};

  always #5 clk = ~clk;

  frame_mem_host dut (
    .clk(clk), .reset(reset), .addr(addr), .dataR(dataR), .dataW(dataW), .en(en), .we(we),
    .start(start), .finish(finish), .go(go), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done)
  );

  function automatic word_t kval(input int k);
    return (k == 3) ? 32'hDEADBEEF : (32'hA5000000 | k);
  endfunction

  task automatic acc_write(input int a, input word_t d);
    en = 1'b1; we = 1'b1; addr = a[15:0]; dataW = d;
    @(negedge clk);
    en = 1'b0; we = 1'b0;
  endtask

  task automatic acc_read(input int a);
    en = 1'b1; we = 1'b0; addr = a[15:0];
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic test_reset;
    en = 0; we = 0; addr = '0; dataW = '0; finish = 0; go = 0;
    in_valid = 0; in_data = '0; out_ready = 0;
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    n_assert++;
    if ({dataR, out_data, start, in_ready, out_valid, busy, done} !== '0)
      begin n_fail++; $display("FAIL reset_outputs: got %h required 0", {dataR, out_data, start, in_ready, out_valid, busy, done}); end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_assert++;
    if (busy !== 1'b0 || in_ready !== 1'b0)
      begin n_fail++; $display("FAIL idle_after_reset: busy=%b in_ready=%b required 0/0", busy, in_ready); end
    go = 1;
    @(negedge clk);
    go = 0;
    in_valid = 1;
    for (int i = 0; i < 10; i++) begin
      in_data = 32'h5000 + i;
      @(negedge clk);
    end
    n_assert++;
    if (in_ready !== 1'b1 || busy !== 1'b1)
      begin n_fail++; $display("FAIL loading_before_abort: in_ready=%b busy=%b required 1/1", in_ready, busy); end
    reset = 1'b0;
    #1;
    n_assert++;
    if ({dataR, out_data, start, in_ready, out_valid, busy, done} !== '0)
      begin n_fail++; $display("FAIL midstream_reset: got %h required 0", {dataR, out_data, start, in_ready, out_valid, busy, done}); end
    @(negedge clk);
    in_valid = 0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_assert++;
    if (busy !== 1'b0)
      begin n_fail++; $display("FAIL stay_idle: busy=%b required 0", busy); end
  endtask

  task automatic test_load;
    int n, guard;
    logic ok;
    n = 0; guard = 0;
    go = 1;
    @(negedge clk);
    go = 0;
    n_assert++;
    if (in_ready !== 1'b1 || busy !== 1'b1)
      begin n_fail++; $display("FAIL load_entry: in_ready=%b busy=%b required 1/1", in_ready, busy); end
    in_valid = 1;
    while (n < IMG && guard < IMG + 50) begin
      in_data = n;
      ok = in_ready;
      @(negedge clk);
      if (ok) n++;
      guard++;
    end
    in_valid = 0;
    n_assert++;
    if (guard !== IMG)
      begin n_fail++; $display("FAIL load_cycles: got %0d required %0d", guard, IMG); end
    n_assert++;
    if (in_ready !== 1'b0 || start !== 1'b1)
      begin n_fail++; $display("FAIL load_to_run: in_ready=%b start=%b required 0/1", in_ready, start); end
  endtask

  task automatic test_acc_read;
    acc_read(5);
    n_assert++;
    if (dataR !== 32'd5) begin n_fail++; $display("FAIL acc_read5: got %h required 5", dataR); end
    @(negedge clk);
    n_assert++;
    if (dataR !== 32'd5) begin n_fail++; $display("FAIL dataR_hold: got %h required 5", dataR); end
  endtask

  task automatic test_range;
    acc_write(50688, 32'h12345678);
    acc_read(50690);
    n_assert++;
    if (dataR !== 32'd0) begin n_fail++; $display("FAIL oob_read: got %h required 0", dataR); end
    acc_read(17920);
    n_assert++;
    if (dataR !== 32'd17920) begin n_fail++; $display("FAIL oob_no_alias: got %h required %h", dataR, 32'd17920); end
  endtask

  task automatic test_acc_write;
    foreach (kpos[i]) if (kpos[i] != 3) acc_write(RB + kpos[i], kval(kpos[i]));
    acc_write(RB + 3, 32'hDEADBEEF);
    acc_read(RB + 3);
    n_assert++;
    if (dataR !== 32'hDEADBEEF) begin n_fail++; $display("FAIL write_then_read: got %h required deadbeef", dataR); end
  endtask

  task automatic test_ignored;
    go = 1; in_valid = 1; in_data = 32'hBAD0BAD0;
    repeat (2) begin
      @(negedge clk);
      n_assert++;
      if (in_ready !== 1'b0 || start !== 1'b1 || busy !== 1'b1)
        begin n_fail++; $display("FAIL ignored_in_run: in_ready=%b start=%b busy=%b required 0/1/1", in_ready, start, busy); end
    end
    go = 0; in_valid = 0;
    acc_read(0);
    n_assert++;
    if (dataR !== 32'd0) begin n_fail++; $display("FAIL mem0_unchanged: got %h required 0", dataR); end
    acc_read(RB + 3);
    n_assert++;
    if (dataR !== 32'hDEADBEEF) begin n_fail++; $display("FAIL result3_unchanged: got %h required deadbeef", dataR); end
  endtask

  task automatic test_finish;
    finish = 1;
    #1;
    n_assert++;
    if (start !== 1'b0) begin n_fail++; $display("FAIL start_drop: got %b required 0", start); end
    @(negedge clk);
    finish = 0;
    n_assert++;
    if (start !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0)
      begin n_fail++; $display("FAIL enter_dump: start=%b busy=%b in_ready=%b required 0/1/0", start, busy, in_ready); end
  endtask

  task automatic test_abort;
    int k, guard;
    k = 0; guard = 0;
    en = 1; we = 0; addr = 16'd5;
    while (k < 100 && guard < 2000) begin
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) begin
        if (k < 4) begin
          n_assert++;
          if (out_data !== kval(k)) begin n_fail++; $display("FAIL abort_dump_word%0d: got %h required %h", k, out_data, kval(k)); end
        end
        k++;
      end
      @(negedge clk);
      guard++;
    end
    en = 0;
    n_assert++;
    if (k !== 100) begin n_fail++; $display("FAIL abort_dump_count: got %0d required 100", k); end
    n_assert++;
    if (dataR !== 32'hDEADBEEF) begin n_fail++; $display("FAIL dataR_hold_dump: got %h required deadbeef", dataR); end
    reset = 1'b0;
    #1;
    n_assert++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0 || dataR !== '0)
      begin n_fail++; $display("FAIL abort_outputs: out_valid=%b busy=%b out_data=%h dataR=%h required 0", out_valid, busy, out_data, dataR); end
    @(negedge clk);
    reset = 1'b1;
    out_ready = 0;
    @(negedge clk);
    n_assert++;
    if (busy !== 1'b0 || out_valid !== 1'b0)
      begin n_fail++; $display("FAIL abort_idle: busy=%b out_valid=%b required 0/0", busy, out_valid); end
  endtask

  task automatic test_dump;
    int k, guard, done_cnt, stray;
    k = 0; guard = 0; done_cnt = 0; stray = 0;
    in_valid = 1; in_data = 32'hFEEDF00D;
    while (busy && guard < 60000) begin
      out_ready = (k < 1000) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (done) done_cnt++;
      if (in_ready) stray++;
      if (out_valid && out_ready) begin
        foreach (kpos[i]) if (k == kpos[i]) begin
          n_assert++;
          if (out_data !== kval(k)) begin n_fail++; $display("FAIL dump_word%0d: got %h required %h", k, out_data, kval(k)); end
        end
        k++;
      end
      @(negedge clk);
      guard++;
    end
    in_valid = 0; out_ready = 0;
    n_assert++;
    if (k !== IMG) begin n_fail++; $display("FAIL dump_count: got %0d required %0d", k, IMG); end
    n_assert++;
    if (done_cnt !== 1) begin n_fail++; $display("FAIL done_pulses: got %0d required 1", done_cnt); end
    n_assert++;
    if (stray !== 0) begin n_fail++; $display("FAIL in_ready_in_dump: got %0d cycles required 0", stray); end
    repeat (2) @(negedge clk);
    n_assert++;
    if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0)
      begin n_fail++; $display("FAIL post_seq_idle: busy=%b done=%b out_valid=%b required 0", busy, done, out_valid); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_acc_read();
    test_range();
    test_acc_write();
    test_ignored();
    test_finish();
    test_abort();
    test_load();
    test_acc_write();
    test_finish();
    test_dump();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
